// File: rtl/encoder_4to2_queued.sv
// rtl/encoder_4to2_queued.sv - queued 4-to-2 priority encoder with valid/ready output (optional ENCODER_OVERRUN_EN)
module encoder_4to2_queued #(
   parameter bit PRIO_HIGH = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i0,
   input  logic       i1,
   input  logic       i2,
   input  logic       i3,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [1:0] code,
   output logic [3:0] pending,
   output logic       overrun
);

   logic [3:0] req;
   logic [3:0] pend_q, pend_d;
   logic [3:0] pend_keep;
   logic [3:0] sel_onehot;
   logic [1:0] sel;
   logic [1:0] code_q, code_d;
   logic       valid_q, valid_d;
   logic       load;

   assign req = {i3, i2, i1, i0};

   // Pick the highest-priority pending bit; the last match in the scan order wins.
   always_comb begin
      sel = 2'b00;
      if (PRIO_HIGH) begin
         for (int n = 0; n < 4; n++) begin
            if (pend_q[n]) sel = 2'(n);
         end
      end else begin
         for (int n = 3; n >= 0; n--) begin
            if (pend_q[n]) sel = 2'(n);
         end
      end
   end

   assign sel_onehot = 4'b0001 << sel;

   // Output register refills when empty or when the consumer takes the current code.
   always_comb begin
      load      = !valid_q || out_ready;
      valid_d   = valid_q;
      code_d    = code_q;
      pend_keep = pend_q;
      if (load) begin
         if (|pend_q) begin
            valid_d   = 1'b1;
            code_d    = sel;
            pend_keep = pend_q & ~sel_onehot;
         end else begin
            valid_d   = 1'b0;
            pend_keep = 4'b0000;
         end
      end
      // A request on the bit being moved out re-arms it, so the event is served again.
      pend_d = pend_keep | req;
   end

   // Pending set and output holding register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q  <= 4'b0000;
         valid_q <= 1'b0;
         code_q  <= 2'b00;
      end else begin
         pend_q  <= pend_d;
         valid_q <= valid_d;
         code_q  <= code_d;
      end
   end

   assign out_valid = valid_q;
   assign code      = code_q;
   assign pending   = pend_q;

`ifdef ENCODER_OVERRUN_EN
   logic ovr_q, ovr_d;

   // A request landing on a bit that stays pending is merged and flagged.
   always_comb begin
      ovr_d = |(req & pend_keep);
   end

   // One-cycle registered overrun pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ovr_q <= 1'b0;
      else     ovr_q <= ovr_d;
   end

   assign overrun = ovr_q;
`else
   assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_encoder_4to2_queued.sv
// tb/tb_encoder_4to2_queued.sv - self-checking bench for encoder_4to2_queued
module tb_encoder_4to2_queued;

`ifdef ENCODER_OVERRUN_EN
   localparam bit OVR_EN = 1'b1;
`else
   localparam bit OVR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       i0, i1, i2, i3;
   logic       out_ready;
   logic       out_valid;
   logic [1:0] code;
   logic [3:0] pending;
   logic       overrun;

   int n_cmp = 0;
   int n_bad = 0;

   encoder_4to2_queued #(.PRIO_HIGH(1'b1)) dut (
      .clk(clk), .rst(rst),
      .i0(i0), .i1(i1), .i2(i2), .i3(i3),
      .out_ready(out_ready),
      .out_valid(out_valid), .code(code),
      .pending(pending), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a set of outstanding events and one output slot.
   // The slot is refilled from the set whenever it is free or being taken;
   // the event chosen is the first one found in priority order i3..i0.
   logic [3:0] m_set;
   logic       m_valid;
   logic [1:0] m_code;
   logic       m_ovr;
   logic [3:0] m_req, m_left;
   int         m_pick;

   function automatic int first_in_priority(input logic [3:0] s);
      int order [4] = '{3, 2, 1, 0};
      for (int k = 0; k < 4; k++) if (s[order[k]]) return order[k];
      return -1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_set   <= 4'b0000;
         m_valid <= 1'b0;
         m_code  <= 2'b00;
         m_ovr   <= 1'b0;
      end else begin
         m_req  = {i3, i2, i1, i0};
         m_left = m_set;
         if (!m_valid || out_ready) begin
            m_pick = first_in_priority(m_set);
            if (m_pick >= 0) begin
               m_valid <= 1'b1;
               m_code  <= 2'(m_pick);
               m_left[m_pick] = 1'b0;
            end else begin
               m_valid <= 1'b0;
            end
         end
         m_set <= m_left | m_req;
         m_ovr <= OVR_EN && ((m_req & m_left) != 4'b0000);
      end
   end

   // Every-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      chk("model.valid",   {7'b0, out_valid}, {7'b0, m_valid});
      chk("model.code",    {6'b0, code},      {6'b0, m_code});
      chk("model.pending", {4'b0, pending},   {4'b0, m_set});
      chk("model.overrun", {7'b0, overrun},   {7'b0, m_ovr});
   end

   task automatic step(input logic [3:0] r);
      {i3, i2, i1, i0} = r;
      @(posedge clk);
      #1;
      {i3, i2, i1, i0} = 4'b0000;
   endtask

   task automatic expect_out(input string nm, input logic v, input logic [1:0] c,
                             input logic [3:0] p);
      chk({nm, ".valid"},   {7'b0, out_valid}, {7'b0, v});
      if (v) chk({nm, ".code"}, {6'b0, code}, {6'b0, c});
      chk({nm, ".pending"}, {4'b0, pending},   {4'b0, p});
   endtask

   initial begin
      rst = 1'b1;
      {i3, i2, i1, i0} = 4'b0000;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("reset.valid",   {7'b0, out_valid}, 8'h00);
      chk("reset.code",    {6'b0, code},      8'h00);
      chk("reset.pending", {4'b0, pending},   8'h00);
      chk("reset.overrun", {7'b0, overrun},   8'h00);
      rst = 1'b0;

      // T1: single event
      out_ready = 1'b1;
      step(4'b0100); expect_out("t1.capture", 1'b0, 2'b00, 4'b0100);
      step(4'b0000); expect_out("t1.serve",   1'b1, 2'b10, 4'b0000);
      step(4'b0000); expect_out("t1.idle",    1'b0, 2'b00, 4'b0000);

      // T2: all four at once, back-to-back in priority order
      step(4'b1111); expect_out("t2.capture", 1'b0, 2'b00, 4'b1111);
      step(4'b0000); expect_out("t2.c0", 1'b1, 2'b11, 4'b0111);
      step(4'b0000); expect_out("t2.c1", 1'b1, 2'b10, 4'b0011);
      step(4'b0000); expect_out("t2.c2", 1'b1, 2'b01, 4'b0001);
      step(4'b0000); expect_out("t2.c3", 1'b1, 2'b00, 4'b0000);
      step(4'b0000); expect_out("t2.idle", 1'b0, 2'b00, 4'b0000);

      // T3: stall, later higher-priority arrival does not preempt
      out_ready = 1'b0;
      step(4'b0010); expect_out("t3.capture", 1'b0, 2'b00, 4'b0010);
      step(4'b1000); expect_out("t3.present", 1'b1, 2'b01, 4'b1000);
      step(4'b0000); expect_out("t3.hold",    1'b1, 2'b01, 4'b1000);
      out_ready = 1'b1;
      step(4'b0000); expect_out("t3.next",    1'b1, 2'b11, 4'b0000);
      step(4'b0000); expect_out("t3.idle",    1'b0, 2'b00, 4'b0000);

      // T4: re-request of a bit already moved to the output
      out_ready = 1'b0;
      step(4'b1000); expect_out("t4.capture", 1'b0, 2'b00, 4'b1000);
      step(4'b0000); expect_out("t4.present", 1'b1, 2'b11, 4'b0000);
      step(4'b1000); expect_out("t4.rereq",   1'b1, 2'b11, 4'b1000);
      chk("t4.overrun", {7'b0, overrun}, 8'h00);
      out_ready = 1'b1;
      step(4'b0000); expect_out("t4.second",  1'b1, 2'b11, 4'b0000);
      step(4'b0000); expect_out("t4.idle",    1'b0, 2'b00, 4'b0000);

      // T5: coalescing into a still-pending bit
      out_ready = 1'b0;
      step(4'b0010); expect_out("t5.capture", 1'b0, 2'b00, 4'b0010);
      step(4'b0000); expect_out("t5.present", 1'b1, 2'b01, 4'b0000);
      step(4'b0001); expect_out("t5.first",   1'b1, 2'b01, 4'b0001);
      chk("t5.ovr0", {7'b0, overrun}, 8'h00);
      step(4'b0001); expect_out("t5.second",  1'b1, 2'b01, 4'b0001);
      chk("t5.ovr1", {7'b0, overrun}, {7'b0, OVR_EN});
      step(4'b0000);
      chk("t5.ovr2", {7'b0, overrun}, 8'h00);
      out_ready = 1'b1;
      step(4'b0000); expect_out("t5.serve",   1'b1, 2'b00, 4'b0000);
      step(4'b0000); expect_out("t5.once",    1'b0, 2'b00, 4'b0000);

      // T7: request on the bit moving out this very edge is served again
      step(4'b0100); expect_out("t7.capture", 1'b0, 2'b00, 4'b0100);
      step(4'b0100); expect_out("t7.move",    1'b1, 2'b10, 4'b0100);
      step(4'b0000); expect_out("t7.again",   1'b1, 2'b10, 4'b0000);
      step(4'b0000); expect_out("t7.idle",    1'b0, 2'b00, 4'b0000);

      // T6: asynchronous reset mid-stream
      out_ready = 1'b0;
      step(4'b1000);
      step(4'b0000);
      step(4'b1011); expect_out("t6.loaded", 1'b1, 2'b11, 4'b1011);
      #2 rst = 1'b1;
      #1;
      chk("t6.valid",   {7'b0, out_valid}, 8'h00);
      chk("t6.code",    {6'b0, code},      8'h00);
      chk("t6.pending", {4'b0, pending},   8'h00);
      chk("t6.overrun", {7'b0, overrun},   8'h00);
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      step(4'b0000); expect_out("t6.after0", 1'b0, 2'b00, 4'b0000);
      step(4'b0000); expect_out("t6.after1", 1'b0, 2'b00, 4'b0000);
      chk("t6.code_after", {6'b0, code}, 8'h00);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: bench did not finish, expected completion");
      $fatal(1);
   end

endmodule
